// File: rtl/distance_pkg.sv
// Shared constants, FSM encoding and BCD nibble-adjust helper for the distance formatter.
// No logic of its own; imported by distance_bcd_formatter and bin2bcd_seq.
// Flow control: not applicable.
package distance_pkg;

    localparam int DIST_W     = 12;
    localparam int BIN_W      = 12;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 12-bit binary to four BCD digits, one bit per cycle.
// Latency: start cycle loads, then 12 shift cycles; done flags the last shift with bcd_out valid that cycle.
// Backpressure: none; a new start simply reloads the shift register.
module bin2bcd_seq
    import distance_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin_in,
    output logic [BCD_W-1:0]   bcd_out,
    output logic               done
);

    logic [BCD_W+BIN_W-1:0] sh_q;
    logic [BCD_W+BIN_W-1:0] sh_next;
    logic [3:0]             cnt_q;

    always_comb begin
        sh_next = {bcd_adjust(sh_q[BCD_W+BIN_W-1:BIN_W]), sh_q[BIN_W-1:0]} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sh_q  <= {{BCD_W{1'b0}}, bin_in};
            cnt_q <= 4'(BIN_W);
        end else if (cnt_q != 4'd0) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Result is taken from the step being committed, so the caller can latch it on the final edge.
    assign bcd_out = sh_next[BCD_W+BIN_W-1:BIN_W];
    assign done    = (cnt_q == 4'd1);

endmodule

// File: rtl/distance_bcd_formatter.sv
// Converts ranging distance samples to 4-digit BCD; optional 4-sample moving average under DIST_AVG_EN.
// Latency: fixed 14 cycles from accepting edge to the bcd_valid cycle.
// Backpressure: none; samples arriving while busy are dropped and counted in drop_cnt (saturating).
module distance_bcd_formatter
    import distance_pkg::*;
#(
    parameter int DIST_W   = distance_pkg::DIST_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              dist_valid,
    output logic [15:0]       bcd_out,
    output logic              bcd_valid,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               drop;
    logic               show;
    logic               conv_start;
    logic               conv_done;
    logic [BIN_W-1:0]   conv_in;
    logic [BCD_W-1:0]   conv_bcd;
    logic [BIN_W-1:0]   din_ext;
    logic [15:0]        bcd_q;
    logic [7:0]         drop_q;

    assign din_ext = BIN_W'(dist_in);
    assign accept  = (state_q == IDLE) && dist_valid;
    assign drop    = (state_q != IDLE) && dist_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dist_valid) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (conv_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        conv_start = (state_q == LOAD);
        bcd_valid  = (state_q == DONE) && show;
    end

`ifdef DIST_AVG_EN
    localparam int AVG_DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W     = BIN_W + AVG_LOG2;
    localparam int FILL_W    = $clog2(AVG_DEPTH + 1);

    logic [BIN_W-1:0]  win_q [AVG_DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [SUM_W-1:0]  win_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) win_q[i] <= '0;
            fill_q <= '0;
        end else if (accept) begin
            win_q[0] <= din_ext;
            for (int i = 1; i < AVG_DEPTH; i++) win_q[i] <= win_q[i-1];
            if (fill_q != FILL_W'(AVG_DEPTH)) fill_q <= fill_q + 1'b1;
        end
    end

    // Window already holds the new sample during LOAD; the converter registers this average.
    always_comb begin
        win_sum = '0;
        for (int i = 0; i < AVG_DEPTH; i++) win_sum = win_sum + SUM_W'(win_q[i]);
    end

    assign conv_in = BIN_W'(win_sum >> AVG_LOG2);
    assign show    = (fill_q == FILL_W'(AVG_DEPTH));
`else
    logic [BIN_W-1:0] sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
        end else if (accept) begin
            sample_q <= din_ext;
        end
    end

    assign conv_in = sample_q;
    assign show    = 1'b1;
`endif

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (conv_start),
        .bin_in  (conv_in),
        .bcd_out (conv_bcd),
        .done    (conv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q <= 16'h0000;
        end else if ((state_q == SHIFT) && conv_done && show) begin
            bcd_q <= conv_bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bcd_out  = bcd_q;
    assign drop_cnt = drop_q;

endmodule
